regfile_write_arbiter: RTL and testbench

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter.sv | 88 ++++++++
 tb/tb_regfile_write_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Two-requester register-file write arbiter: round-robin grant, registered write port, saturating contention counter.
// Define FIXED_PRIORITY_EN to make requester 0 always win contention (the round-robin pointer is then removed).
module regfile_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              hold,
  input  logic              valid0,
  input  logic              valid1,
  input  logic [ADDR_W-1:0] reg0,
  input  logic [ADDR_W-1:0] reg1,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  output logic              ready0,
  output logic              ready1,
  output logic              writeEnable,
  output logic [ADDR_W-1:0] writeReg,
  output logic [DATA_W-1:0] writeData,
  output logic [7:0]        conflictCount
);

  logic              prefer0;
  logic              accept;
  logic              contended;
  logic [ADDR_W-1:0] grant_reg;
  logic [DATA_W-1:0] grant_data;

`ifdef FIXED_PRIORITY_EN
  assign prefer0 = 1'b1;
`else
  // last == 1 means requester 1 was granted most recently, so requester 0 wins the next contention.
  logic last;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last <= 1'b1;
    end else if (accept) begin
      last <= ready1;
    end
  end

  assign prefer0 = last;
`endif

  assign contended = valid0 & valid1 & ~hold;

  // Grants are gated by reset so nothing is consumed while the block is held in reset.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
    ready0 = 1'b0;
    ready1 = 1'b0;
    if (reset && !hold) begin
      if (valid0 && (!valid1 || prefer0)) begin
        ready0 = 1'b1;
      end else if (valid1) begin
        ready1 = 1'b1;
      end
    end
  end

  assign accept     = ready0 | ready1;
  assign grant_reg  = ready1 ? reg1 : reg0;
  assign grant_data = ready1 ? data1 : data0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      writeEnable   <= 1'b0;
      writeReg      <= '0;
      writeData     <= '0;
      conflictCount <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      writeEnable <= 1'b0;
      if (accept) begin
        writeReg    <= grant_reg;
        writeData   <= grant_data;
        // Writes to register 0 are consumed but never strobed into the file.
        writeEnable <= (grant_reg != '0);
      end
      if (contended && (conflictCount != 8'hFF)) begin
        conflictCount <= conflictCount + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_regfile_write_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        hold = 1'b0;
  logic        valid0 = 1'b0;
  logic        valid1 = 1'b0;
  logic [4:0]  reg0 = '0;
  logic [4:0]  reg1 = '0;
  logic [31:0] data0 = '0;
  logic [31:0] data1 = '0;
  logic        ready0, ready1, writeEnable;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic [7:0]  conflictCount;

  int checks = 0;
  int errors = 0;

`ifdef FIXED_PRIORITY_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clock(clock), .reset(reset), .hold(hold),
    .valid0(valid0), .valid1(valid1), .reg0(reg0), .reg1(reg1),
    .data0(data0), .data1(data1), .ready0(ready0), .ready1(ready1),
    .writeEnable(writeEnable), .writeReg(writeReg), .writeData(writeData),
    .conflictCount(conflictCount)
  );

  always #5 clock = ~clock;

  // Reference model: who won last, how many contended edges, what the write port shows.
  int          m_last;
  int          m_cnt;
  bit          m_we;
  logic [4:0]  m_reg;
  logic [31:0] m_data;
  int          exp_grant;
  logic        obs_r0, obs_r1;

  function automatic int model_grant(bit h, bit v0, bit v1);
    if (h || !(v0 || v1)) return -1;
    if (v0 && !v1) return 0;
    if (v1 && !v0) return 1;
    if (FIXED) return 0;
    return (m_last == 0) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_last = 1; m_cnt = 0; m_we = 1'b0; m_reg = '0; m_data = '0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0; hold = 1'b0; valid0 = 1'b0; valid1 = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    model_reset();
  endtask

  // One clock cycle: drive at negedge, sample ready, clock, then advance the model.
  task automatic step(input bit h, input bit v0, input logic [4:0] r0, input logic [31:0] d0,
                      input bit v1, input logic [4:0] r1, input logic [31:0] d1);
    @(negedge clock);
    hold = h; valid0 = v0; reg0 = r0; data0 = d0; valid1 = v1; reg1 = r1; data1 = d1;
    #1;
    obs_r0 = ready0; obs_r1 = ready1;
    exp_grant = model_grant(h, v0, v1);
    @(posedge clock);
    #1;
    if (!h && v0 && v1 && m_cnt < 255) m_cnt++;
    if (exp_grant >= 0) begin
      m_last = exp_grant;
      m_reg  = (exp_grant == 1) ? r1 : r0;
      m_data = (exp_grant == 1) ? d1 : d0;
      m_we   = (m_reg != 0);
    end else begin
      m_we = 1'b0;
    end
  endtask

  task automatic test_reset();
    valid0 = 1'b1; valid1 = 1'b1; reg0 = 5'd1; reg1 = 5'd2;
    #12;
    checks++; if ({ready0, ready1} !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", {ready0, ready1}); end
    checks++; if (writeEnable !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", writeEnable); end
    checks++; if (writeReg !== 5'd0 || writeData !== 32'd0) begin errors++; $display("FAIL reset_port got %0h/%0h exp 0/0", writeReg, writeData); end
    checks++; if (conflictCount !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", conflictCount); end
    do_reset();
  endtask

  task automatic test_single();
    step(0, 1, 5'd3, 32'hA5A5A5A5, 0, 5'd0, 32'd0);
    checks++; if (obs_r0 !== 1'b1 || obs_r1 !== 1'b0) begin errors++; $display("FAIL single_ready got %b%b exp 10", obs_r0, obs_r1); end
    checks++; if (writeEnable !== 1'b1 || writeReg !== 5'd3 || writeData !== 32'hA5A5A5A5)
      begin errors++; $display("FAIL single_write got %b/%0d/%h exp 1/3/a5a5a5a5", writeEnable, writeReg, writeData); end
    step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    checks++; if (writeEnable !== 1'b0 || writeReg !== 5'd3 || writeData !== 32'hA5A5A5A5)
      begin errors++; $display("FAIL single_idle got %b/%0d/%h exp 0/3/a5a5a5a5", writeEnable, writeReg, writeData); end
  endtask

  task automatic test_round_robin();
    int g;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      g = FIXED ? 0 : (i % 2);
      step(0, 1, 5'd1, 32'h100 + i, 1, 5'd2, 32'h200 + i);
      checks++; if (obs_r0 !== (g == 0) || obs_r1 !== (g == 1))
        begin errors++; $display("FAIL rr_grant%0d got %b%b exp grant %0d", i, obs_r0, obs_r1, g); end
      checks++; if (writeEnable !== 1'b1 || writeReg !== ((g == 1) ? 5'd2 : 5'd1))
        begin errors++; $display("FAIL rr_write%0d got %b/%0d exp 1/%0d", i, writeEnable, writeReg, (g == 1) ? 2 : 1); end
      checks++; if (conflictCount !== 8'(i + 1))
        begin errors++; $display("FAIL rr_cnt%0d got %0d exp %0d", i, conflictCount, i + 1); end
    end
  endtask

  task automatic test_reg_zero();
    step(0, 0, 5'd0, 32'd0, 1, 5'd0, 32'hFFFFFFFF);
    checks++; if (obs_r1 !== 1'b1 || obs_r0 !== 1'b0) begin errors++; $display("FAIL zero_ready got %b%b exp 01", obs_r0, obs_r1); end
    checks++; if (writeEnable !== 1'b0 || writeReg !== 5'd0)
      begin errors++; $display("FAIL zero_write got %b/%0d exp 0/0", writeEnable, writeReg); end
  endtask

  task automatic test_hold();
    int cnt_before;
    cnt_before = m_cnt;
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 5'd4, 32'h44, 1, 5'd5, 32'h55);
      checks++; if (obs_r0 !== 1'b0 || obs_r1 !== 1'b0 || writeEnable !== 1'b0)
        begin errors++; $display("FAIL hold%0d got r=%b%b we=%b exp r=00 we=0", i, obs_r0, obs_r1, writeEnable); end
      checks++; if (conflictCount !== 8'(cnt_before))
        begin errors++; $display("FAIL hold_cnt%0d got %0d exp %0d", i, conflictCount, cnt_before); end
    end
    step(0, 1, 5'd4, 32'h44, 1, 5'd5, 32'h55);
    checks++; if (obs_r0 !== (exp_grant == 0) || obs_r1 !== (exp_grant == 1))
      begin errors++; $display("FAIL hold_release got %b%b exp grant %0d", obs_r0, obs_r1, exp_grant); end
    checks++; if (writeReg !== m_reg || writeData !== m_data)
      begin errors++; $display("FAIL hold_release_write got %0d/%h exp %0d/%h", writeReg, writeData, m_reg, m_data); end
  endtask

  task automatic test_same_reg();
    do_reset();
    step(0, 1, 5'd7, 32'h11, 1, 5'd7, 32'h22);
    checks++; if (writeEnable !== 1'b1 || writeReg !== 5'd7 || writeData !== 32'h11)
      begin errors++; $display("FAIL same_first got %b/%0d/%h exp 1/7/11", writeEnable, writeReg, writeData); end
    step(0, 0, 5'd0, 32'd0, 1, 5'd7, 32'h22);
    checks++; if (writeEnable !== 1'b1 || writeReg !== 5'd7 || writeData !== 32'h22)
      begin errors++; $display("FAIL same_second got %b/%0d/%h exp 1/7/22", writeEnable, writeReg, writeData); end
  endtask

  task automatic test_random();
    bit          p0, p1, h;
    logic [4:0]  r0, r1;
    logic [31:0] d0, d1;
    p0 = 0; p1 = 0; r0 = '0; r1 = '0; d0 = '0; d1 = '0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (!p0 && $urandom_range(1, 0) == 1) begin p0 = 1; r0 = 5'($urandom_range(3, 0)); d0 = $urandom; end
      if (!p1 && $urandom_range(1, 0) == 1) begin p1 = 1; r1 = 5'($urandom_range(3, 0)); d1 = $urandom; end
      h = ($urandom_range(4, 0) == 0);
      step(h, p0, r0, d0, p1, r1, d1);
      checks++; if (obs_r0 !== (exp_grant == 0) || obs_r1 !== (exp_grant == 1))
        begin errors++; $display("FAIL rand_ready%0d got %b%b exp grant %0d", i, obs_r0, obs_r1, exp_grant); end
      checks++; if (writeEnable !== m_we || writeReg !== m_reg || writeData !== m_data || conflictCount !== 8'(m_cnt))
        begin errors++; $display("FAIL rand_out%0d got %b/%0d/%h/%0d exp %b/%0d/%h/%0d", i,
          writeEnable, writeReg, writeData, conflictCount, m_we, m_reg, m_data, m_cnt); end
      if (exp_grant == 0) p0 = 0;
      if (exp_grant == 1) p1 = 0;
    end
  endtask

  task automatic test_saturation_and_reset();
    do_reset();
    for (int i = 0; i < 300; i++) step(0, 1, 5'd1, $urandom, 1, 5'd2, $urandom);
    checks++; if (conflictCount !== 8'd255) begin errors++; $display("FAIL sat_cnt got %0d exp 255", conflictCount); end
    step(0, 1, 5'd9, 32'hDEADBEEF, 0, 5'd0, 32'd0);
    checks++; if (writeEnable !== 1'b1) begin errors++; $display("FAIL midrst_pre got %b exp 1", writeEnable); end
    valid0 = 1'b1;
    #2 reset = 1'b0;
    #1;
    checks++; if (writeEnable !== 1'b0 || conflictCount !== 8'd0 || ready0 !== 1'b0)
      begin errors++; $display("FAIL midrst_now got we=%b cnt=%0d r0=%b exp 0/0/0", writeEnable, conflictCount, ready0); end
    @(negedge clock);
    valid0 = 1'b0; valid1 = 1'b0; reset = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      checks++; if (writeEnable !== 1'b0 || writeReg !== 5'd0)
        begin errors++; $display("FAIL midrst_after%0d got %b/%0d exp 0/0", i, writeEnable, writeReg); end
    end
  endtask

  initial begin
    model_reset();
    exp_grant = -1; obs_r0 = 1'b0; obs_r1 = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_reg_zero();
    test_hold();
    test_same_reg();
    test_random();
    test_saturation_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
